// File: rtl/hsm_bus_pkg.sv
// Shared types and constants for the HSM pin-bus transceiver.
// The state encoding, idle bus word and FIFO depth check live here.
package hsm_bus_pkg;

  typedef enum logic [1:0] {
    ST_RELEASE = 2'd0,
    ST_RX      = 2'd1,
    ST_TX      = 2'd2
  } state_e;

  // Value driven on every pin when the TX FIFO has nothing to offer.
  localparam logic BUS_IDLE_BIT = 1'b0;

  function automatic bit is_pow2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head and a separate count register.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               push_i,
  input  logic [DATA_WIDTH-1:0]              push_data_i,
  input  logic                               pop_i,
  output logic [DATA_WIDTH-1:0]              head_o,
  output logic                               full_o,
  output logic                               empty_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // Head is read asynchronously for fall-through, so this maps to distributed RAM.
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/hsm_bus_transceiver.sv
// Bidirectional host pin bus with RX/TX FIFOs, input synchronisers and
// a counted tri-state turnaround before the FPGA drives the pins.
module hsm_bus_transceiver
  import hsm_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TURNAROUND = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            chip_select,
  input  logic                            strobe,
  inout  wire  [DATA_WIDTH-1:0]           data_pins,
  input  logic [DATA_WIDTH-1:0]           tx_data,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  output logic [DATA_WIDTH-1:0]           rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] tx_count,
  output logic                            rx_overflow,
  output logic                            tx_underflow,
  input  logic                            clear_errors
);

  localparam int TA_W = $clog2(TURNAROUND + 1);
  localparam logic [TA_W-1:0] TA_LAST = TA_W'(TURNAROUND - 1);

  if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (TURNAROUND < 1) begin : g_bad_turnaround
    $error("TURNAROUND must be at least 1");
  end

  logic                  cs_meta_q, cs_s_q;
  logic                  stb_meta_q, stb_s_q, stb_d_q;
  logic [DATA_WIDTH-1:0] data_meta_q, data_s_q;
  logic                  stb_rise;

  state_e                state_q, state_d;
  logic [TA_W-1:0]       ta_cnt_q, ta_cnt_d;
  logic                  rx_overflow_q, rx_overflow_d;
  logic                  tx_underflow_q, tx_underflow_d;

  logic                  rx_push_req, rx_pop, rx_full, rx_empty;
  logic                  tx_pop_req, tx_push, tx_full, tx_empty;
  logic [DATA_WIDTH-1:0] tx_head, tx_word;
  logic                  bus_oe;

  // Data takes the same two stages as strobe so the sampled word lines up with stb_s.
  always_ff @(posedge clock) begin
    if (reset) begin
      cs_meta_q      <= 1'b0;
      cs_s_q         <= 1'b0;
      stb_meta_q     <= 1'b0;
      stb_s_q        <= 1'b0;
      stb_d_q        <= 1'b0;
      data_meta_q    <= '0;
      data_s_q       <= '0;
      state_q        <= ST_RELEASE;
      ta_cnt_q       <= '0;
      rx_overflow_q  <= 1'b0;
      tx_underflow_q <= 1'b0;
    end else begin
      cs_meta_q      <= chip_select;
      cs_s_q         <= cs_meta_q;
      stb_meta_q     <= strobe;
      stb_s_q        <= stb_meta_q;
      stb_d_q        <= stb_s_q;
      data_meta_q    <= data_pins;
      data_s_q       <= data_meta_q;
      state_q        <= state_d;
      ta_cnt_q       <= ta_cnt_d;
      rx_overflow_q  <= rx_overflow_d;
      tx_underflow_q <= tx_underflow_d;
    end
  end

  assign stb_rise = stb_s_q & ~stb_d_q;

  always_comb begin
    state_d  = state_q;
    ta_cnt_d = ta_cnt_q;
    case (state_q)
      ST_RELEASE: begin
        if (cs_s_q) begin
          state_d  = ST_RX;
          ta_cnt_d = '0;
        end else if (ta_cnt_q == TA_LAST) begin
          state_d  = ST_TX;
          ta_cnt_d = '0;
        end else begin
          ta_cnt_d = ta_cnt_q + TA_W'(1);
        end
      end
      ST_RX:   if (!cs_s_q) state_d = ST_RELEASE;
      ST_TX:   if (cs_s_q)  state_d = ST_RELEASE;
      default: state_d = ST_RELEASE;
    endcase
  end

  // A pop is suppressed once cs_s rises, even if the state register still reads TX.
  assign rx_push_req = (state_q == ST_RX) & stb_rise;
  assign tx_pop_req  = (state_q == ST_TX) & ~cs_s_q & stb_rise;
  assign rx_pop      = rx_valid & rx_ready;
  assign tx_ready    = ~tx_full | tx_pop_req;
  assign tx_push     = tx_valid & tx_ready;
  assign rx_valid    = ~rx_empty;

  always_comb begin
    rx_overflow_d  = (rx_push_req & rx_full & ~rx_pop) | (rx_overflow_q & ~clear_errors);
    tx_underflow_d = (tx_pop_req & tx_empty) | (tx_underflow_q & ~clear_errors);
  end

  assign rx_overflow  = rx_overflow_q;
  assign tx_underflow = tx_underflow_q;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (rx_push_req),
    .push_data_i (data_s_q),
    .pop_i       (rx_pop),
    .head_o      (rx_data),
    .full_o      (rx_full),
    .empty_o     (rx_empty),
    .count_o     (rx_count)
  );

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (tx_push),
    .push_data_i (tx_data),
    .pop_i       (tx_pop_req),
    .head_o      (tx_head),
    .full_o      (tx_full),
    .empty_o     (tx_empty),
    .count_o     (tx_count)
  );

  // Enable drops combinationally with cs_s, one cycle ahead of the state register.
  assign bus_oe  = (state_q == ST_TX) & ~cs_s_q;
  assign tx_word = tx_empty ? {DATA_WIDTH{BUS_IDLE_BIT}} : tx_head;

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_pin
    assign data_pins[gi] = bus_oe ? tx_word[gi] : 1'bz;
  end

endmodule

// File: tb/tb_hsm_bus_transceiver.sv
// Directed bench for hsm_bus_transceiver with FIFO_DEPTH=4, TURNAROUND=2.
// Host pins change on the falling edge; outputs are checked on the falling edge.
module tb_hsm_bus_transceiver;

  logic       clock;
  logic       reset;
  logic       chip_select;
  logic       strobe;
  wire  [7:0] data_pins;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [2:0] rx_count;
  logic [2:0] tx_count;
  logic       rx_overflow;
  logic       tx_underflow;
  logic       clear_errors;

  logic       host_en;
  logic [7:0] host_data;

  int checks = 0;
  int errors = 0;

  assign data_pins = host_en ? host_data : 8'hzz;

  hsm_bus_transceiver #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4),
    .TURNAROUND (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .chip_select  (chip_select),
    .strobe       (strobe),
    .data_pins    (data_pins),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_count     (rx_count),
    .tx_count     (tx_count),
    .rx_overflow  (rx_overflow),
    .tx_underflow (tx_underflow),
    .clear_errors (clear_errors)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic strobe_pulse();
    strobe = 1'b1;
    cyc(3);
    strobe = 1'b0;
    cyc(3);
  endtask

  task automatic strobe_word(input logic [7:0] d);
    host_data = d;
    cyc(3);
    strobe_pulse();
  endtask

  initial begin
    reset = 1'b1; chip_select = 1'b1; strobe = 1'b0;
    host_en = 1'b1; host_data = 8'h00;
    tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; clear_errors = 1'b0;
    cyc(3);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_count", rx_count, 0);
    check("rst_tx_count", tx_count, 0);
    check("rst_flags", {rx_overflow, tx_underflow}, 0);
    check("rst_oe", dut.bus_oe, 0);
    reset = 1'b0;
    cyc(4);

    // RX burst with first-word latency
    host_data = 8'h11;
    cyc(3);
    strobe = 1'b1;
    cyc(1); check("rx_lat_k", rx_valid, 0);
    cyc(1); check("rx_lat_k1", rx_valid, 0);
    cyc(1); check("rx_lat_k2", rx_valid, 1);
    check("rx_first", rx_data, 8'h11);
    strobe = 1'b0;
    cyc(3);
    strobe_word(8'h22);
    strobe_word(8'h33);
    check("rx_peak", rx_count, 3);
    rx_ready = 1'b1;
    check("rx_d0", rx_data, 8'h11);
    cyc(1); check("rx_d1", rx_data, 8'h22);
    cyc(1); check("rx_d2", rx_data, 8'h33);
    cyc(1); check("rx_drained", rx_valid, 0);
    rx_ready = 1'b0;
    check("rx_cnt0", rx_count, 0);

    // RX overflow
    for (int i = 1; i <= 4; i++) strobe_word(8'(i));
    check("ovf_cnt4", rx_count, 4);
    check("ovf_not_yet", rx_overflow, 0);
    strobe_word(8'h05);
    check("ovf_cnt_hold", rx_count, 4);
    check("ovf_flag", rx_overflow, 1);
    rx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("ovf_data", rx_data, 32'(i));
      cyc(1);
    end
    rx_ready = 1'b0;
    check("ovf_empty", rx_valid, 0);
    clear_errors = 1'b1;
    cyc(1);
    clear_errors = 1'b0;
    check("ovf_clear", rx_overflow, 0);

    // TX with turnaround and underflow
    tx_valid = 1'b1; tx_data = 8'hA5;
    cyc(1);
    tx_data = 8'h5A;
    cyc(1);
    tx_valid = 1'b0;
    check("tx_load", tx_count, 2);
    host_en = 1'b0;
    chip_select = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("tx_turn_z", dut.bus_oe, 0);
    end
    cyc(1);
    check("tx_drive_oe", dut.bus_oe, 1);
    check("tx_drive_a5", data_pins, 8'hA5);
    strobe_pulse();
    check("tx_pop1", data_pins, 8'h5A);
    check("tx_cnt1", tx_count, 1);
    check("tx_uf0", tx_underflow, 0);
    strobe_pulse();
    check("tx_pop2", data_pins, 8'h00);
    check("tx_cnt0", tx_count, 0);
    check("tx_uf_empty", tx_underflow, 0);
    strobe = 1'b1;
    cyc(2);
    clear_errors = 1'b1;
    cyc(1);
    check("tx_uf_set_wins", tx_underflow, 1);
    clear_errors = 1'b0;
    check("tx_idle_zero", data_pins, 8'h00);
    strobe = 1'b0;
    cyc(3);
    check("tx_uf_sticky", tx_underflow, 1);

    // Direction switch mid-TX with a strobe that must not pop
    tx_valid = 1'b1; tx_data = 8'hA5;
    cyc(1);
    tx_valid = 1'b0;
    check("sw_drive", data_pins, 8'hA5);
    check("sw_cnt", tx_count, 1);
    chip_select = 1'b1;
    strobe = 1'b1;
    cyc(2);
    check("sw_release", dut.bus_oe, 0);
    cyc(2);
    strobe = 1'b0;
    cyc(3);
    check("sw_no_pop", tx_count, 1);
    check("sw_no_push", rx_count, 0);
    chip_select = 1'b0;
    cyc(4);
    check("sw_turn_z", dut.bus_oe, 0);
    cyc(1);
    check("sw_redrive_oe", dut.bus_oe, 1);
    check("sw_redrive", data_pins, 8'hA5);

    // Full TX FIFO: local write and pin pop in the same cycle
    tx_valid = 1'b1;
    tx_data = 8'hB1; cyc(1);
    tx_data = 8'hB2; cyc(1);
    tx_data = 8'hB3; cyc(1);
    tx_data = 8'hC4;
    check("full_cnt", tx_count, 4);
    check("full_not_ready", tx_ready, 0);
    strobe = 1'b1;
    cyc(1); check("full_k", tx_count, 4);
    cyc(1); check("full_ready_pop", tx_ready, 1);
    cyc(1);
    check("full_cnt_hold", tx_count, 4);
    check("full_head", data_pins, 8'hB1);
    check("full_ready_after", tx_ready, 0);
    tx_valid = 1'b0;
    strobe = 1'b0;
    cyc(3);
    strobe_pulse(); check("drain_b2", data_pins, 8'hB2);
    strobe_pulse(); check("drain_b3", data_pins, 8'hB3);
    strobe_pulse(); check("drain_c4", data_pins, 8'hC4);
    strobe_pulse(); check("drain_empty", tx_count, 0);
    check("drain_zero", data_pins, 8'h00);

    // Reset mid-TX with three words queued
    tx_valid = 1'b1;
    tx_data = 8'h71; cyc(1);
    tx_data = 8'h72; cyc(1);
    tx_data = 8'h73; cyc(1);
    tx_valid = 1'b0;
    check("pre_rst_cnt", tx_count, 3);
    check("pre_rst_head", data_pins, 8'h71);
    strobe = 1'b1;
    reset = 1'b1;
    cyc(1);
    check("mid_rst_oe", dut.bus_oe, 0);
    check("mid_rst_tx_cnt", tx_count, 0);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_flags", {rx_overflow, tx_underflow}, 0);
    reset = 1'b0;
    strobe = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
